// File: rtl/layer_param_loader_pkg.sv
// Shared definitions for the layer parameter loader: fixed-point word width
// and the words-per-node rule that the layer and the loader must agree on.
package layer_param_loader_pkg;

  localparam int unsigned FP_N = 16;

  // Each node takes sx weights, one bias and one end-marker word.
  function automatic int unsigned loader_wpn(input int unsigned sx);
    return sx + 2;
  endfunction

endpackage

// File: rtl/layer_param_loader.sv
// Streams one layer's parameter words onto the layer parameter bus, pulsing
// exactly one node's shift enable per accepted word, node 0 first.
module layer_param_loader
  import layer_param_loader_pkg::*;
#(
  parameter int unsigned sx = 99,
  parameter int unsigned sl = 99,
  parameter int unsigned n  = FP_N
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  clr,
  input  logic [n-1:0]                          in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [n-1:0]                          bus,
  output logic [sl-1:0]                         we,
  output logic [((sl > 1) ? $clog2(sl) : 1)-1:0] node_idx,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned WPN = loader_wpn(sx);
  localparam int unsigned NW  = (sl > 1) ? $clog2(sl) : 1;
  localparam int unsigned WW  = $clog2(WPN);

  localparam logic [WW-1:0] LAST_WORD = WW'(WPN - 1);
  localparam logic [NW-1:0] LAST_NODE = NW'(sl - 1);
  // Node k owns we[sl-1-k], so node 0's enable is the MSB.
  localparam logic [sl-1:0] WE_NODE0 = {1'b1, {(sl - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   word_cnt;
  logic [NW-1:0]   node_cnt;
  logic            accept;
  logic            last_word;
  logic            restart;

  assign in_ready  = (state_q == LOAD) && !clr;
  assign accept    = in_valid && in_ready;
  assign last_word = (node_cnt == LAST_NODE) && (word_cnt == LAST_WORD);
  assign restart   = start && (state_q != LOAD);

  assign busy      = (state_q == LOAD);
  assign done      = (state_q == DONE);
  assign node_idx  = node_cnt;

  always_comb begin
    // NOTE: next state defaults to the current state first so no path through
    // the case leaves state_d unassigned, which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (accept && last_word) state_d = DONE;
      DONE:    if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a simultaneous start.
    if (clr) state_d = IDLE;
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order between blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      node_cnt <= '0;
    end else if (clr || restart) begin
      word_cnt <= '0;
      node_cnt <= '0;
    end else if (accept) begin
      if (word_cnt == LAST_WORD) begin
        word_cnt <= '0;
        // The final node's counter parks at sl-1 until the next start clears it.
        if (node_cnt != LAST_NODE) node_cnt <= node_cnt + NW'(1);
      end else begin
        word_cnt <= word_cnt + WW'(1);
      end
    end
  end

  // NOTE: bus and we are plain output registers, so they take the async reset;
  // the node shift registers they feed are deliberately never cleared here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus <= '0;
      we  <= '0;
    end else begin
      we <= accept ? (WE_NODE0 >> node_cnt) : '0;
      if (accept) bus <= in_data;
    end
  end

endmodule

// File: tb/tb_layer_param_loader.sv
// Scoreboard bench for layer_param_loader with sx=2, sl=3 (4 words per node).
module tb_layer_param_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clr;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bus;
  logic [2:0]  we;
  logic [1:0]  node_idx;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  layer_param_loader #(.sx(2), .sl(3), .n(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .clr      (clr),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bus      (bus),
    .we       (we),
    .node_idx (node_idx),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic [2:0]  we;
    logic [15:0] bus;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Stream word index -> expected enable: node 0 -> 100, node 1 -> 010, node 2 -> 001.
  function automatic logic [2:0] we_for(input int idx);
    case (idx / 4)
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every enable pulse must match the next expected word.
  always @(negedge clk) begin
    if (rst === 1'b0 && we !== 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(we), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_we", 32'(we), 32'(e.we));
        check("sb_bus", 32'(bus), 32'(e.bus));
      end
    end
  end

  task automatic feed(input int first_idx, input int cnt, input logic [15:0] base, input bit gap);
    for (int j = 0; j < cnt; j++) begin
      in_valid = 1'b1;
      in_data  = base + 16'(j);
      exp_q.push_back('{we: we_for(first_idx + j), bus: base + 16'(j)});
      tick();
      if (gap && j < cnt - 1) begin
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        tick();
        check("gap_we", 32'(we), 32'd0);
        check("gap_bus_hold", 32'(bus), 32'(base + 16'(j)));
        check("gap_node_hold", 32'(node_idx), 32'((first_idx + j + 1) / 4));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", 32'(we), 32'd0);
    check("rst_bus", 32'(bus), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_node_idx", 32'(node_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // 1: async reset while loading node 1, with a pulse in flight
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    feed(0, 5, 16'h0050, 1'b0);
    check("t1_pre_we", 32'(we), 32'(3'b010));
    check("t1_pre_node", 32'(node_idx), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t1_rst_we", 32'(we), 32'd0);
    check("t1_rst_bus", 32'(bus), 32'd0);
    check("t1_rst_node", 32'(node_idx), 32'd0);
    check("t1_rst_busy", 32'(busy), 32'd0);
    check("t1_rst_ready", 32'(in_ready), 32'd0);
    check("t1_rst_done", 32'(done), 32'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();

    // 2: full load, in_valid held high, then an excess word
    pulse_start();
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_ready", 32'(in_ready), 32'd1);
    check("t2_node0", 32'(node_idx), 32'd0);
    check("t2_done0", 32'(done), 32'd0);
    feed(0, 12, 16'h0001, 1'b0);
    check("t2_done", 32'(done), 32'd1);
    check("t2_busy_end", 32'(busy), 32'd0);
    check("t2_ready_end", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 16'h000D;
    tick();
    in_valid = 1'b0;
    check("t2_excess_we", 32'(we), 32'd0);
    check("t2_excess_bus", 32'(bus), 32'h000C);
    check("t2_excess_done", 32'(done), 32'd1);
    drain();

    // 3: in_valid toggling every cycle
    pulse_start();
    feed(0, 12, 16'h0100, 1'b1);
    check("t3_done", 32'(done), 32'd1);
    drain();

    // 4: abort after 5 accepts, with a word offered during clr
    pulse_start();
    feed(0, 5, 16'h0200, 1'b0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0BAD;
    #1;
    check("t4_clr_ready", 32'(in_ready), 32'd0);
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("t4_idle_busy", 32'(busy), 32'd0);
    check("t4_idle_done", 32'(done), 32'd0);
    check("t4_idle_ready", 32'(in_ready), 32'd0);
    check("t4_idle_node", 32'(node_idx), 32'd0);
    check("t4_idle_we", 32'(we), 32'd0);
    drain();
    pulse_start();
    feed(0, 1, 16'h0300, 1'b0);

    // 5: start during LOAD on word 6 is ignored; word 7 still lands in node 1
    feed(1, 4, 16'h0301, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h0305;
    start    = 1'b1;
    exp_q.push_back('{we: we_for(5), bus: 16'h0305});
    tick();
    start = 1'b0;
    check("t5_node_after_start", 32'(node_idx), 32'd1);
    feed(6, 6, 16'h0306, 1'b0);
    check("t5_done", 32'(done), 32'd1);
    drain();

    // 6: restart from DONE reloads from node 0
    pulse_start();
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_done", 32'(done), 32'd0);
    check("t6_node", 32'(node_idx), 32'd0);
    feed(0, 4, 16'h0400, 1'b0);
    check("t6_node1", 32'(node_idx), 32'd1);
    feed(4, 8, 16'h0404, 1'b0);
    check("t6_done_end", 32'(done), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
